// File: rtl/monopix_out_buffer_pkg.sv
// Shared defaults and helpers for the MIO output word buffer.
// The pointer width is derived here so the top and the RAM agree on it.
package monopix_out_buffer_pkg;

    localparam int unsigned DEPTH_DEF           = 16;
    localparam int unsigned NEAR_FULL_LEVEL_DEF = 12;
    localparam int unsigned WORD_W              = 32;
    localparam logic [7:0]  LOST_CNT_MAX        = 8'hFF;

    typedef logic [WORD_W-1:0] word_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/monopix_out_buffer_if.sv
// Word handshake between arbiter, buffer and the downstream SRAM FIFO.
// The slave modport is the buffer; master is the arbiter/SRAM side.
interface monopix_out_buffer_if;
    import monopix_out_buffer_pkg::*;

    logic  IN_WRITE;
    word_t IN_DATA;
    logic  IN_READY;
    logic  OUT_WRITE;
    word_t OUT_DATA;
    logic  OUT_FULL;

    modport slave (
        input  IN_WRITE,
        input  IN_DATA,
        output IN_READY,
        output OUT_WRITE,
        output OUT_DATA,
        input  OUT_FULL
    );

    modport master (
        output IN_WRITE,
        output IN_DATA,
        input  IN_READY,
        input  OUT_WRITE,
        input  OUT_DATA,
        output OUT_FULL
    );

endinterface

// File: rtl/monopix_out_buffer_ram.sv
// Simple dual-port word store: synchronous write, asynchronous read.
// Written without reset so it maps onto distributed RAM.
module out_buffer_ram
    import monopix_out_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  word_t            i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output word_t            o_rd_data
);

    word_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/monopix_out_buffer.sv
// Elastic show-ahead buffer from the readout arbiter to the MIO SRAM FIFO,
// with a fill-level veto and lost/forwarded word counters.
module monopix_out_buffer
    import monopix_out_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH           = DEPTH_DEF,
    parameter  int unsigned NEAR_FULL_LEVEL = NEAR_FULL_LEVEL_DEF,
    localparam int unsigned PTR_W           = ptr_width(DEPTH),
    localparam int unsigned FILL_W          = PTR_W + 1
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST_N,
    monopix_out_buffer_if.slave     bus,
    input  logic                    FLUSH,
    input  logic                    CLEAR_CNT,
    output logic                    NEAR_FULL,
    output logic [FILL_W-1:0]       FILL,
    output logic [7:0]              LOST_CNT,
    output logic [31:0]             WORD_CNT
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(NEAR_FULL_LEVEL);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic [7:0]        r_lost_cnt;
    logic [31:0]       r_word_cnt;

    logic  w_in_ready;
    logic  w_out_write;
    logic  w_push;
    logic  w_pop;
    logic  w_lost;
    word_t w_rd_data;

    // Ready depends only on registered fill, so a pop cannot open a slot
    // for a push in the same cycle.
    assign w_in_ready  = (r_fill != FILL_FULL);
    assign w_out_write = (r_fill != '0) & ~bus.OUT_FULL & ~FLUSH;
    assign w_push      = bus.IN_WRITE & w_in_ready & ~FLUSH;
    assign w_pop       = w_out_write;
    assign w_lost      = bus.IN_WRITE & ~w_in_ready & ~FLUSH;

    out_buffer_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .i_clk     (BUS_CLK),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.IN_DATA),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_lost_cnt <= '0;
            r_word_cnt <= '0;
        end else if (CLEAR_CNT) begin
            r_lost_cnt <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_lost && (r_lost_cnt != LOST_CNT_MAX)) begin
                r_lost_cnt <= r_lost_cnt + 8'd1;
            end
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_WRITE = w_out_write;
    assign bus.OUT_DATA  = w_rd_data;

    assign NEAR_FULL = (r_fill >= FILL_NEAR);
    assign FILL      = r_fill;
    assign LOST_CNT  = r_lost_cnt;
    assign WORD_CNT  = r_word_cnt;

endmodule

// File: doc/monopix_out_buffer.md
# monopix_out_buffer

Elastic word buffer between the readout arbiter output (32-bit words with write/ready handshake) and the external SRAM FIFO interface of the MIO board. It absorbs bursts from the arbiter and keeps it stalled only when the local buffer is really full. It produces a fill-level veto (`NEAR_FULL`) suitable for the TLU trigger veto, and keeps lost-word and forwarded-word counters for debugging.

## Interface
- `DEPTH`, 16: buffer depth in 32-bit words; power of two, 4..256.
- `NEAR_FULL_LEVEL`, 12: fill level at or above which `NEAR_FULL` asserts; 1..DEPTH.
- `BUS_CLK` in 1: single clock for all logic.
- `BUS_RST_N` in 1: reset, asynchronous and active-low; deassertion is synchronous to `BUS_CLK` externally.
- `IN_WRITE` in 1: arbiter write strobe; one word per cycle when high.
- `IN_DATA` in 32: arbiter word.
- `IN_READY` out 1: buffer can accept a word this cycle.
- `OUT_WRITE` out 1: word on `OUT_DATA` is valid and is consumed at this edge.
- `OUT_DATA` out 32: head-of-buffer word (show-ahead).
- `OUT_FULL` in 1: downstream SRAM FIFO full; blocks `OUT_WRITE`.
- `FLUSH` in 1: synchronous discard of all buffered words.
- `CLEAR_CNT` in 1: synchronous clear of both counters.
- `NEAR_FULL` out 1: fill level is at or above `NEAR_FULL_LEVEL`.
- `FILL` out $clog2(DEPTH)+1: current word count.
- `LOST_CNT` out 8: words offered while `IN_READY` was low; saturates at 255.
- `WORD_CNT` out 32: words forwarded downstream; wraps modulo 2^32.

## Operation
- State: write pointer, read pointer (each $clog2(DEPTH) bits, wrapping), `FILL` counter (0..DEPTH), memory array, two counters.
- Push when `IN_WRITE & IN_READY`: store `IN_DATA` at the write pointer, then increment the write pointer.
- Pop when `OUT_WRITE`: increment the read pointer and `WORD_CNT`.
- Fill update:
  - push and pop in the same cycle: `FILL` unchanged;
  - push only: +1;
  - pop only: −1.
- `IN_READY` = (`FILL` != DEPTH). It is combinational from registers and never depends on `IN_WRITE`.
- `OUT_WRITE` = (`FILL` != 0) & !`OUT_FULL`. It is combinational. `OUT_DATA` = mem[read pointer].
- Full condition (`FILL` == DEPTH):
  - `IN_READY` is low, so a concurrent pop does not enable a push in the same cycle;
  - `IN_WRITE` in this state increments `LOST_CNT` (saturating) and the word is discarded.
- Empty condition: `OUT_WRITE` is low and `OUT_DATA` is don't-care.
- `NEAR_FULL` = (`FILL` >= NEAR_FULL_LEVEL).
- `FLUSH` sets pointers and `FILL` to 0 at the next edge. It overrides any push or pop in the same cycle: no `WORD_CNT` or `LOST_CNT` update from that cycle's strobes, and `OUT_WRITE` is forced low while `FLUSH` is high.
- `CLEAR_CNT` zeroes `LOST_CNT` and `WORD_CNT`. It overrides increments in the same cycle. Buffer contents are unaffected.
- Reset (any time, including mid-burst):
  - pointers, `FILL`, `LOST_CNT` and `WORD_CNT` go to 0;
  - `IN_READY`=1, `OUT_WRITE`=0, `NEAR_FULL`=0;
  - memory contents are not reset.

## Timing
- Latency: a word pushed at edge n is presented with `OUT_WRITE`=1 in the cycle after edge n, and popped at edge n+1 if `OUT_FULL` is low.
- Throughput: one word per cycle in and out at the same time, with no bubbles.
- `OUT_FULL` is sampled combinationally. Downstream must raise it before the edge at which it can no longer accept a word.
- `NEAR_FULL`, `IN_READY` and `FILL` reflect the registered state after the last edge; there is no look-ahead.
- Word order is strictly preserved, including across pointer wrap-around.

## Structure
- Package `monopix_out_buffer_pkg`: default `DEPTH` and `NEAR_FULL_LEVEL`, the `LOST_CNT` saturation value (8'hFF), and the pointer-width function.
- One sub-module, `out_buffer_ram`: simple dual-port RAM, DEPTH×32, synchronous write and asynchronous read, to map to distributed RAM.
- Pointer, fill, handshake and counter logic live in the top module.

## Test plan
- Reset, then push 5 words 0x00000001..0x00000005 back-to-back with `OUT_FULL`=1. Expect `FILL`=5 and `OUT_WRITE`=0. Drop `OUT_FULL` and expect 5 consecutive `OUT_WRITE` cycles in order, then `WORD_CNT`=5.
- With `OUT_FULL`=1, push 16 words (DEPTH=16). Expect `NEAR_FULL` to rise after the 12th push and `IN_READY`=0 after the 16th. Hold `IN_WRITE` for 3 more cycles and expect `LOST_CNT`=3, `FILL`=16.
- Continuous streaming of 100 words with `OUT_FULL`=0. Expect each word to appear 1 cycle after its push, `FILL` ≤ 1, no pointer-wrap errors, and `WORD_CNT`=100.
- With the buffer full and `OUT_FULL`=0, hold `IN_WRITE`. Expect pop without push in that cycle, then `IN_READY`=1 and push the following cycle; `LOST_CNT` increments by 1 for the blocked cycle.
- Assert `FLUSH` with `FILL`=7 and `IN_WRITE`=1 in the same cycle. Expect `FILL`=0 next cycle, `OUT_WRITE`=0 during `FLUSH`, and `WORD_CNT` unchanged.
- Pulse `BUS_RST_N` low mid-stream with `LOST_CNT`=255. Expect all outputs at reset values immediately, without waiting for a clock edge.
